// File: rtl/irq_sched.sv
// Interrupt scheduler: gathers 32 sources into a pending set, picks one eligible
// winner (fixed or round-robin priority) and holds it on cpu_irq until its eoi.
module irq_sched #(
  parameter logic [31:0] LATCHED_IRQ = 32'hffff_ffff,
  parameter logic [31:0] MASKED_IRQ  = 32'h0000_0000,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src_irq,
  output logic [31:0] cpu_irq,
  input  logic [31:0] cpu_eoi,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        active_valid,
  output logic [4:0]  active_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELIVER = 2'd1,
    GAP     = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] enable_q, enable_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] src_prev_q;
  logic [31:0] served_q, served_d;
  logic [31:0] cfg_rdata_q, cfg_rdata_d;
  logic [4:0]  winner_q, winner_d;
  logic [4:0]  rr_ptr_q, rr_ptr_d;

  logic [31:0] eligible;
  logic [31:0] win_onehot;
  logic [4:0]  pick;
  logic [4:0]  rr_idx;
  logic        eoi_done;
  logic [31:0] soft_set, w1c_clr, eoi_clr, deliver_vec, hw_set, hold;

  assign eligible     = pending_q & enable_q & ~MASKED_IRQ;
  assign win_onehot   = 32'd1 << winner_q;
  assign active_valid = (state_q == DELIVER);
  assign active_id    = active_valid ? winner_q : 5'd0;
  assign cpu_irq      = active_valid ? win_onehot : 32'd0;
  assign cfg_rdata    = cfg_rdata_q;
  assign eoi_done     = active_valid && cpu_eoi[winner_q];

  // Winner selection; round-robin scans rr_ptr+1 .. rr_ptr+32 (mod 32).
  always_comb begin : pick_comb
    logic found;
    pick   = 5'd0;
    rr_idx = 5'd0;
    found  = 1'b0;
    if (ROUND_ROBIN) begin
      for (int k = 1; k <= 32; k++) begin
        rr_idx = rr_ptr_q + 5'(k);
        if (!found && eligible[rr_idx]) begin
          pick  = rr_idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        if (eligible[i]) pick = 5'(i);
      end
    end
  end

  // Pending update: hold/clear first, then every set source overrides a clear.
  always_comb begin
    soft_set    = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : 32'd0;
    w1c_clr     = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 32'd0;
    eoi_clr     = eoi_done ? win_onehot : 32'd0;
    deliver_vec = active_valid ? win_onehot : 32'd0;
    hw_set      = (LATCHED_IRQ & src_irq & ~src_prev_q) | (~LATCHED_IRQ & src_irq);
    hold        = (LATCHED_IRQ & pending_q) | (~LATCHED_IRQ & deliver_vec);
    pending_d   = ((hold & ~(w1c_clr | eoi_clr)) | hw_set | soft_set) & ~MASKED_IRQ;
    enable_d    = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : enable_q;
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    served_d = served_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (eligible != 32'd0) begin
          winner_d = pick;
          state_d  = DELIVER;
        end
      end
      DELIVER: begin
        if (eoi_done) begin
          served_d = served_q + 32'd1;
          rr_ptr_d = winner_q;
          state_d  = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads see register contents from before any same-cycle write.
  always_comb begin
    cfg_rdata_d = 32'd0;
    case (cfg_addr)
      2'd0: cfg_rdata_d = enable_q;
      2'd1: cfg_rdata_d = pending_q;
      2'd2: cfg_rdata_d = served_q;
      2'd3: cfg_rdata_d = {26'd0, active_valid, active_id};
      default: cfg_rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      enable_q    <= 32'd0;
      pending_q   <= 32'd0;
      src_prev_q  <= 32'd0;
      served_q    <= 32'd0;
      cfg_rdata_q <= 32'd0;
      winner_q    <= 5'd0;
      rr_ptr_q    <= 5'd31;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      src_prev_q  <= src_irq;
      served_q    <= served_d;
      cfg_rdata_q <= cfg_rdata_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_irq_sched.sv
// Bench for irq_sched: a fixed-priority instance with a level source on bit 4,
// and a round-robin instance with bit 0 hard-masked.
module tb_irq_sched;

  localparam logic [31:0] LAT_A = 32'hffff_ffef;
  localparam logic [31:0] MSK_B = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] a_src, a_eoi, a_wdata, a_cpu_irq, a_rdata;
  logic        a_we, a_av;
  logic [1:0]  a_addr;
  logic [4:0]  a_aid;

  logic [31:0] b_src, b_eoi, b_wdata, b_cpu_irq, b_rdata;
  logic        b_we, b_av;
  logic [1:0]  b_addr;
  logic [4:0]  b_aid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];

  // Reference model of instance A, kept in spec terms.
  bit [31:0] m_pend, m_en, m_prev, m_served, m_rdata;
  bit        m_busy, m_gap;
  int        m_win;

  irq_sched #(.LATCHED_IRQ(LAT_A), .MASKED_IRQ(32'h0), .ROUND_ROBIN(1'b0)) dut_a (
    .clk(clk), .reset(reset), .src_irq(a_src), .cpu_irq(a_cpu_irq), .cpu_eoi(a_eoi),
    .cfg_we(a_we), .cfg_addr(a_addr), .cfg_wdata(a_wdata), .cfg_rdata(a_rdata),
    .active_valid(a_av), .active_id(a_aid)
  );

  irq_sched #(.LATCHED_IRQ(32'hffff_ffff), .MASKED_IRQ(MSK_B), .ROUND_ROBIN(1'b1)) dut_b (
    .clk(clk), .reset(reset), .src_irq(b_src), .cpu_irq(b_cpu_irq), .cpu_eoi(b_eoi),
    .cfg_we(b_we), .cfg_addr(b_addr), .cfg_wdata(b_wdata), .cfg_rdata(b_rdata),
    .active_valid(b_av), .active_id(b_aid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_prev = '0; m_served = '0; m_rdata = '0;
    m_busy = 1'b0; m_gap = 1'b0; m_win = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_src = '0; a_eoi = '0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_src = '0; b_eoi = '0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock edge of the model, using pre-edge state for every decision.
  task automatic model_step(input bit [31:0] src, eoi, input bit we, input bit [1:0] addr,
                            input bit [31:0] wdata);
    bit [31:0] np;
    bit        set, clr, dlv;
    int        pick;
    case (addr)
      2'd0: m_rdata = m_en;
      2'd1: m_rdata = m_pend;
      2'd2: m_rdata = m_served;
      default: m_rdata = m_busy ? {26'd0, 1'b1, 5'(m_win)} : 32'd0;
    endcase
    for (int i = 0; i < 32; i++) begin
      dlv = m_busy && (m_win == i);
      set = (we && addr == 2'd2 && wdata[i]) || (LAT_A[i] ? (src[i] && !m_prev[i]) : src[i]);
      clr = (we && addr == 2'd1 && wdata[i]) || (dlv && eoi[i]);
      if (set) np[i] = 1'b1;
      else if (clr) np[i] = 1'b0;
      else if (LAT_A[i]) np[i] = m_pend[i];
      else np[i] = dlv;
    end
    if (m_busy) begin
      if (eoi[m_win]) begin
        m_served = m_served + 1;
        m_busy = 1'b0;
        m_gap = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      pick = -1;
      for (int i = 31; i >= 0; i--) if (m_pend[i] && m_en[i]) pick = i;
      if (pick >= 0) begin
        m_busy = 1'b1;
        m_win = pick;
      end
    end
    m_pend = np;
    if (we && addr == 2'd0) m_en = wdata;
    m_prev = src;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_a(input logic [31:0] src, eoi, input logic we, input logic [1:0] addr,
                        input logic [31:0] wdata);
    a_src = src; a_eoi = eoi; a_we = we; a_addr = addr; a_wdata = wdata;
    @(posedge clk);
    model_step(src, eoi, we, addr, wdata);
    #1;
  endtask

  task automatic tick_b(input logic [31:0] src, eoi, input logic we, input logic [1:0] addr,
                        input logic [31:0] wdata);
    b_src = src; b_eoi = eoi; b_we = we; b_addr = addr; b_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (a_cpu_irq !== 32'h0) begin n_fail++; $display("FAIL reset_irq: got %h expected %h", a_cpu_irq, 32'h0); end
    n_checks++; if ({a_av, a_aid} !== 6'h0) begin n_fail++; $display("FAIL reset_active: got %h expected %h", {a_av, a_aid}, 6'h0); end
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", a_rdata, 32'h0); end
    n_checks++; if (b_cpu_irq !== 32'h0) begin n_fail++; $display("FAIL reset_irq_b: got %h expected %h", b_cpu_irq, 32'h0); end
    tick_a(0, 0, 1'b0, 2'd2, 0);
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_served: got %h expected %h", a_rdata, 32'h0); end
  endtask

  task automatic test_basic();
    do_reset();
    tick_a(0, 0, 1'b1, 2'd0, 32'h1);
    tick_a(32'h1, 0, 1'b0, 2'd1, 0);
    tick_a(0, 0, 1'b0, 2'd1, 0);
    n_checks++; if (a_rdata !== 32'h1) begin n_fail++; $display("FAIL basic_pending: got %h expected %h", a_rdata, 32'h1); end
    n_checks++; if (a_cpu_irq !== 32'h1) begin n_fail++; $display("FAIL basic_irq: got %h expected %h", a_cpu_irq, 32'h1); end
    n_checks++; if ({a_av, a_aid} !== 6'h20) begin n_fail++; $display("FAIL basic_active: got %h expected %h", {a_av, a_aid}, 6'h20); end
    tick_a(0, 32'h1, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h0) begin n_fail++; $display("FAIL basic_eoi_irq: got %h expected %h", a_cpu_irq, 32'h0); end
    tick_a(0, 0, 1'b0, 2'd1, 0);
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL basic_pend_clr: got %h expected %h", a_rdata, 32'h0); end
    tick_a(0, 0, 1'b0, 2'd2, 0);
    n_checks++; if (a_rdata !== 32'h1) begin n_fail++; $display("FAIL basic_served: got %h expected %h", a_rdata, 32'h1); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    tick_a(0, 0, 1'b1, 2'd0, 32'hffff_ffff);
    tick_a(32'h88, 0, 1'b0, 2'd0, 0);
    tick_a(0, 0, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h8) begin n_fail++; $display("FAIL prio_first: got %h expected %h", a_cpu_irq, 32'h8); end
    tick_a(0, 32'h8, 1'b0, 2'd0, 0);
    tick_a(0, 0, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h0) begin n_fail++; $display("FAIL prio_gap: got %h expected %h", a_cpu_irq, 32'h0); end
    tick_a(0, 0, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h80) begin n_fail++; $display("FAIL prio_second: got %h expected %h", a_cpu_irq, 32'h80); end
    tick_a(0, 32'h80, 1'b0, 2'd0, 0);
    tick_a(0, 0, 1'b0, 2'd2, 0);
    n_checks++; if (a_rdata !== 32'h2) begin n_fail++; $display("FAIL prio_served: got %h expected %h", a_rdata, 32'h2); end
  endtask

  task automatic test_level();
    do_reset();
    tick_a(0, 0, 1'b1, 2'd0, 32'h10);
    tick_a(32'h10, 0, 1'b0, 2'd0, 0);
    tick_a(32'h10, 0, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h10) begin n_fail++; $display("FAIL level_irq: got %h expected %h", a_cpu_irq, 32'h10); end
    tick_a(32'h10, 0, 1'b0, 2'd0, 0);
    tick_a(0, 0, 1'b0, 2'd1, 0);
    tick_a(0, 0, 1'b0, 2'd1, 0);
    n_checks++; if (a_rdata !== 32'h10) begin n_fail++; $display("FAIL level_hold_pend: got %h expected %h", a_rdata, 32'h10); end
    n_checks++; if (a_cpu_irq !== 32'h10) begin n_fail++; $display("FAIL level_hold_irq: got %h expected %h", a_cpu_irq, 32'h10); end
    tick_a(0, 32'h10, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h0) begin n_fail++; $display("FAIL level_eoi_irq: got %h expected %h", a_cpu_irq, 32'h0); end
    tick_a(0, 0, 1'b0, 2'd1, 0);
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL level_pend_clr: got %h expected %h", a_rdata, 32'h0); end
  endtask

  task automatic test_set_wins();
    do_reset();
    tick_a(0, 0, 1'b1, 2'd0, 32'h2);
    tick_a(32'h2, 0, 1'b0, 2'd0, 0);
    tick_a(0, 0, 1'b0, 2'd0, 0);
    tick_a(0, 32'h200, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h2) begin n_fail++; $display("FAIL spurious_eoi: got %h expected %h", a_cpu_irq, 32'h2); end
    tick_a(32'h2, 32'h2, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h0) begin n_fail++; $display("FAIL setwins_eoi: got %h expected %h", a_cpu_irq, 32'h0); end
    tick_a(0, 0, 1'b0, 2'd1, 0);
    n_checks++; if (a_rdata !== 32'h2) begin n_fail++; $display("FAIL setwins_pend: got %h expected %h", a_rdata, 32'h2); end
    tick_a(0, 0, 1'b0, 2'd0, 0);
    n_checks++; if (a_cpu_irq !== 32'h2) begin n_fail++; $display("FAIL setwins_redeliver: got %h expected %h", a_cpu_irq, 32'h2); end
  endtask

  task automatic test_reset_mid_deliver();
    do_reset();
    tick_a(0, 0, 1'b1, 2'd0, 32'h300);
    tick_a(32'h300, 0, 1'b0, 2'd0, 0);
    tick_a(0, 0, 1'b0, 2'd1, 0);
    tick_a(0, 0, 1'b0, 2'd1, 0);
    n_checks++; if (a_rdata !== 32'h300) begin n_fail++; $display("FAIL midrst_pend: got %h expected %h", a_rdata, 32'h300); end
    n_checks++; if (a_cpu_irq !== 32'h100) begin n_fail++; $display("FAIL midrst_irq: got %h expected %h", a_cpu_irq, 32'h100); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    n_checks++; if (a_cpu_irq !== 32'h0) begin n_fail++; $display("FAIL midrst_irq_clr: got %h expected %h", a_cpu_irq, 32'h0); end
    n_checks++; if (a_av !== 1'b0) begin n_fail++; $display("FAIL midrst_av: got %h expected %h", a_av, 1'b0); end
    tick_a(0, 0, 1'b0, 2'd1, 0);
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_pend_clr: got %h expected %h", a_rdata, 32'h0); end
    tick_a(0, 0, 1'b0, 2'd0, 0);
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_enable: got %h expected %h", a_rdata, 32'h0); end
    tick_a(0, 0, 1'b0, 2'd3, 0);
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_status: got %h expected %h", a_rdata, 32'h0); end
  endtask

  task automatic test_masked();
    do_reset();
    tick_b(0, 0, 1'b1, 2'd0, 32'hffff_ffff);
    tick_b(32'h1, 0, 1'b0, 2'd1, 0);
    tick_b(0, 0, 1'b0, 2'd1, 0);
    tick_b(0, 0, 1'b0, 2'd1, 0);
    n_checks++; if (b_rdata !== 32'h0) begin n_fail++; $display("FAIL masked_pend: got %h expected %h", b_rdata, 32'h0); end
    n_checks++; if (b_cpu_irq !== 32'h0) begin n_fail++; $display("FAIL masked_irq: got %h expected %h", b_cpu_irq, 32'h0); end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_id;
    int waited;
    do_reset();
    exp_q = '{5'd2, 5'd5, 5'd2, 5'd5};
    tick_b(0, 0, 1'b1, 2'd0, 32'hffff_ffff);
    tick_b(32'h24, 0, 1'b0, 2'd0, 0);
    while (exp_q.size() > 0) begin
      exp_id = exp_q.pop_front();
      waited = 0;
      while (b_cpu_irq == 32'h0 && waited < 10) begin
        tick_b(0, 0, 1'b0, 2'd0, 0);
        waited++;
      end
      n_checks++; if (waited >= 10) begin n_fail++; $display("FAIL rr_timeout: got no delivery expected id %0d", exp_id); end
      n_checks++; if (b_cpu_irq !== (32'd1 << exp_id)) begin n_fail++; $display("FAIL rr_order: got %h expected %h", b_cpu_irq, 32'd1 << exp_id); end
      n_checks++; if (b_aid !== exp_id) begin n_fail++; $display("FAIL rr_id: got %0d expected %0d", b_aid, exp_id); end
      tick_b(32'd1 << exp_id, 32'd1 << exp_id, 1'b0, 2'd0, 0);
    end
    tick_b(0, 0, 1'b0, 2'd2, 0);
    n_checks++; if (b_rdata !== 32'd4) begin n_fail++; $display("FAIL rr_served: got %h expected %h", b_rdata, 32'd4); end
  endtask

  task automatic test_random();
    logic [31:0] src, eoi, wdata, exp_irq;
    logic        we;
    logic [1:0]  addr;
    do_reset();
    tick_a(0, 0, 1'b1, 2'd0, 32'hffff_ffff);
    for (int c = 0; c < 400; c++) begin
      src = $urandom & $urandom & $urandom;
      eoi = 32'd0;
      if (m_busy && $urandom_range(0, 3) == 0) eoi = 32'd1 << m_win;
      if ($urandom_range(0, 7) == 0) eoi = eoi | (32'd1 << $urandom_range(0, 31));
      we    = ($urandom_range(0, 7) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      tick_a(src, eoi, we, addr, wdata);
      exp_irq = m_busy ? (32'd1 << m_win) : 32'd0;
      n_checks++; if (a_cpu_irq !== exp_irq) begin n_fail++; $display("FAIL rand_irq c%0d: got %h expected %h", c, a_cpu_irq, exp_irq); end
      n_checks++; if (a_av !== m_busy) begin n_fail++; $display("FAIL rand_av c%0d: got %h expected %h", c, a_av, m_busy); end
      n_checks++; if (a_aid !== (m_busy ? 5'(m_win) : 5'd0)) begin n_fail++; $display("FAIL rand_id c%0d: got %0d expected %0d", c, a_aid, m_busy ? m_win : 0); end
      n_checks++; if (a_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, a_rdata, m_rdata); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_fixed_priority();
    test_level();
    test_set_wins();
    test_reset_mid_deliver();
    test_masked();
    test_round_robin();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
